// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and stop encodings, the TX state encoding, and parity helpers.
// The receiver imports this package as well.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_WAIT   = 3'd1;
  localparam logic [2:0] TX_START  = 3'd2;
  localparam logic [2:0] TX_DATA   = 3'd3;
  localparam logic [2:0] TX_PARITY = 3'd4;
  localparam logic [2:0] TX_STOP1  = 3'd5;
  localparam logic [2:0] TX_STOP2  = 3'd6;

  typedef enum logic [2:0] {
    StIdle   = TX_IDLE,
    StWait   = TX_WAIT,
    StStart  = TX_START,
    StData   = TX_DATA,
    StParity = TX_PARITY,
    StStop1  = TX_STOP1,
    StStop2  = TX_STOP2
  } tx_state_e;

  // 2'b11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] ptype);
    return (ptype == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side request/status bundle of the UART transmit framer.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  send;
  logic [1:0]            parity_type;
  logic                  stop_bits;
  logic                  tx_out;
  logic                  active;
  logic                  done;

  modport master (
    output data_in, send, parity_type, stop_bits,
    input  tx_out, active, done
  );

  modport slave (
    input  data_in, send, parity_type, stop_bits,
    output tx_out, active, done
  );
endinterface

// File: rtl/baud_edge_det.sv
// Registers the baud_gen square wave and emits a one-clock pulse on each rising edge.
module baud_edge_det (
  input  logic clock,
  input  logic rst,
  input  logic baud_out,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_out;
    end
  end

  assign tick = baud_out & ~baud_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: latches a word on send and shifts it out LSB-first as
// start, data, optional parity and one or two stop bits, one bit per baud tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               baud_out,
  uart_tx_frame_if.slave     bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic                  tick;
  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CntW-1:0]       cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop_two_q;
  logic                  tx_q;
  logic                  active_q;
  logic                  done_q;
  logic [7:0]            data_ext;

  assign data_ext = 8'(bus.data_in);

  baud_edge_det u_baud_edge_det (
    .clock    (clock),
    .rst      (rst),
    .baud_out (baud_out),
    .tick     (tick)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.send) begin
            // Parity is resolved here so later data_in changes cannot reach the frame.
            shift_q    <= bus.data_in;
            par_en_q   <= parity_enabled(bus.parity_type);
            par_bit_q  <= parity_bit(data_ext, bus.parity_type);
            stop_two_q <= (bus.stop_bits == STOP_TWO);
            active_q   <= 1'b1;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (tick) begin
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            cnt_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop1;
              end
            end else begin
              tx_q    <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop1;
          end
        end
        StStop1: begin
          if (tick) begin
            if (stop_two_q) begin
              state_q <= StStop2;
            end else begin
              state_q  <= StIdle;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        StStop2: begin
          if (tick) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          tx_q     <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.active = active_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized frame checks for uart_tx_frame against a bit-list frame model.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int unsigned DW = 8;

  logic clock    = 1'b0;
  logic rst      = 1'b0;
  logic baud_out = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   exp_bits[$];

  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .rst      (rst),
    .baud_out (baud_out),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  // Toggle every 8 clocks: one bit time is 16 clocks.
  always begin
    repeat (8) @(posedge clock);
    #1 baud_out = ~baud_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: list of line levels, one per bit time.
  task automatic build_frame(input logic [7:0] data, input logic [1:0] ptype, input logic stop);
    int ones;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(data[i]);
    ones = $countones(data);
    if (ptype == 2'b01) exp_bits.push_back((ones % 2) == 0);
    if (ptype == 2'b10) exp_bits.push_back((ones % 2) == 1);
    exp_bits.push_back(1'b1);
    if (stop) exp_bits.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] ptype, input logic stop);
    @(negedge clock);
    bus.data_in     = data;
    bus.parity_type = ptype;
    bus.stop_bits   = stop;
    bus.send        = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    check("active_on_accept", bus.active, 1);
    check("tx_idle_on_accept", bus.tx_out, 1);
  endtask

  // act: 0 none, 1 re-pulse send with other inputs, 2 drop held send, 3 assert reset.
  task automatic check_frame(input logic [7:0] data, input logic [1:0] ptype, input logic stop,
                             input int act_at, input int act, output int lat);
    int   n;
    logic exp_act;
    bit   aborted;
    aborted = 1'b0;
    build_frame(data, ptype, stop);
    n   = exp_bits.size();
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (bus.tx_out !== 1'b0 && lat < 40);
    check("start_seen", bus.tx_out, 0);
    if (bus.tx_out !== 1'b0) return;
    for (int i = 0; i < 16 * n; i++) begin
      if (i > 0) @(negedge clock);
      if (i % 16 == 0 || i % 16 == 8 || i % 16 == 15) begin
        check($sformatf("bit%0d_at%0d", i / 16, i % 16), bus.tx_out, exp_bits[i / 16]);
        check("active_in_frame", bus.active, 1);
        check("done_in_frame", bus.done, 0);
      end
      if (i == act_at) begin
        if (act == 1) begin
          bus.send        = 1'b1;
          bus.data_in     = 8'hFF;
          bus.parity_type = 2'b10;
          bus.stop_bits   = 1'b1;
        end else if (act == 2) begin
          bus.send = 1'b0;
        end else if (act == 3) begin
          rst = 1'b0;
          #1;
          check("rst_tx", bus.tx_out, 1);
          check("rst_active", bus.active, 0);
          check("rst_done", bus.done, 0);
          aborted = 1'b1;
          break;
        end
      end
      if (act == 1 && i == act_at + 1) bus.send = 1'b0;
    end
    if (aborted) return;
    @(negedge clock);
    exp_act = bus.send;
    check("done_pulse", bus.done, 1);
    check("active_end", bus.active, 0);
    check("tx_end", bus.tx_out, 1);
    @(negedge clock);
    check("done_single", bus.done, 0);
    check("active_after", bus.active, exp_act);
  endtask

  initial begin
    int   lat;
    int   busy;
    logic [7:0] rd;
    logic [1:0] rp;
    logic       rs;
    bus.send        = 1'b0;
    bus.data_in     = '0;
    bus.parity_type = PAR_NONE;
    bus.stop_bits   = STOP_ONE;

    repeat (3) @(negedge clock);
    check("reset_tx", bus.tx_out, 1);
    check("reset_active", bus.active, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clock);

    send_frame(8'hA5, PAR_NONE, STOP_ONE);
    check_frame(8'hA5, PAR_NONE, STOP_ONE, -1, 0, lat);
    check("latency_a5", (lat >= 1 && lat <= 16), 1);

    send_frame(8'h07, PAR_EVEN, STOP_ONE);
    check_frame(8'h07, PAR_EVEN, STOP_ONE, -1, 0, lat);
    send_frame(8'h07, PAR_ODD, STOP_ONE);
    check_frame(8'h07, PAR_ODD, STOP_ONE, -1, 0, lat);

    send_frame(8'h00, PAR_NONE, STOP_TWO);
    check_frame(8'h00, PAR_NONE, STOP_TWO, -1, 0, lat);

    // Mid-frame request with new word and config must be ignored and not queued.
    send_frame(8'h3C, PAR_NONE, STOP_ONE);
    check_frame(8'h3C, PAR_NONE, STOP_ONE, 16 * 3 + 4, 1, lat);
    busy = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.active !== 1'b0 || bus.tx_out !== 1'b1) busy++;
    end
    check("no_queued_frame", busy, 0);

    // Held send: second frame accepted on the clock after done, start on the next tick.
    @(negedge clock);
    bus.data_in     = 8'h55;
    bus.parity_type = PAR_NONE;
    bus.stop_bits   = STOP_ONE;
    bus.send        = 1'b1;
    check_frame(8'h55, PAR_NONE, STOP_ONE, -1, 0, lat);
    check_frame(8'h55, PAR_NONE, STOP_ONE, 20, 2, lat);
    check("b2b_start_lat", lat, 15);

    // Reset in the middle of data bit 4 (line bit 5).
    send_frame(8'hC3, PAR_EVEN, STOP_ONE);
    check_frame(8'hC3, PAR_EVEN, STOP_ONE, 16 * 5 + 8, 3, lat);
    repeat (2) @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    send_frame(8'h96, PAR_ODD, STOP_TWO);
    check_frame(8'h96, PAR_ODD, STOP_TWO, -1, 0, lat);

    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) @(negedge clock);
      send_frame(rd, rp, rs);
      check_frame(rd, rp, rs, -1, 0, lat);
      check("latency_rand", (lat >= 1 && lat <= 16), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
